// File: rtl/vga_src_sched_pkg.sv
// Shared types and constants for the VGA source scheduler.
// Holds the FSM encoding, the blanking coordinate and the RGB565 black pixel.
package vga_src_sched_pkg;

  typedef enum logic [1:0] {
    StShow  = 2'd0,
    StPend  = 2'd1,
    StBlank = 2'd2
  } state_e;

  localparam logic [9:0]  InvCoordDef = 10'h3ff;
  localparam logic [15:0] Rgb565Black = 16'h0000;

  // Next source index with wrap at num.
  function automatic logic [1:0] next_src(input logic [1:0] cur, input int unsigned num);
    return (32'(cur) == num - 32'd1) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/vga_src_sched_frame_tick.sv
// Frame-start detector: one-clock pulse on the first clock where the raster sits at (0,0).
module vga_src_sched_frame_tick (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       fs_o
);

  logic origin;
  logic origin_q;

  assign origin = (pix_x_i == 10'd0) && (pix_y_i == 10'd0);
  assign fs_o   = origin && !origin_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      origin_q <= 1'b0;
    end else begin
      origin_q <= origin;
    end
  end

endmodule

// File: rtl/vga_src_sched.sv
// Frame-synchronous selector for the VGA pixel generators; switches source only at
// frame start and inserts one black frame between sources.
module vga_src_sched
  import vga_src_sched_pkg::*;
#(
  parameter int unsigned NumSrc    = 3,
  parameter logic [9:0]  FrameHold = 10'd60,
  parameter logic [9:0]  InvCoord  = InvCoordDef
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [9:0]            pix_x_i,
  input  logic [9:0]            pix_y_i,
  input  logic [16*NumSrc-1:0]  src_data_i,
  input  logic                  next_req_i,
  input  logic                  auto_en_i,
  input  logic                  sel_valid_i,
  input  logic [1:0]            sel_id_i,
  output logic                  sel_ready_o,
  output logic                  sel_err_o,
  output logic [15:0]           pix_data_o,
  output logic [1:0]            cur_src_o,
  output logic                  switching_o
);

  localparam logic [9:0] HoldLast = FrameHold - 10'd1;

  state_e      state_q, state_d;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [1:0]  cur_src_q, cur_src_d;
  logic        sel_err_q, sel_err_d;
  logic        vld_q, vld_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [15:0] src_pix;
  logic        fs;
  logic        sel_accept;
  logic        sel_id_ok;

  vga_src_sched_frame_tick u_frame_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pix_x_i (pix_x_i),
    .pix_y_i (pix_y_i),
    .fs_o    (fs)
  );

  assign sel_ready_o = (state_q == StShow);
  assign switching_o = (state_q != StShow);
  assign sel_err_o   = sel_err_q;
  assign cur_src_o   = cur_src_q;
  assign pix_data_o  = pix_data_q;

  assign sel_accept = sel_valid_i && sel_ready_o;
  assign sel_id_ok  = (32'(sel_id_i) < NumSrc);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    tgt_d       = tgt_q;
    cur_src_d   = cur_src_q;
    sel_err_d   = 1'b0;
    unique case (state_q)
      StShow: begin
        if (!auto_en_i) begin
          frame_cnt_d = '0;
        end else if (fs && (frame_cnt_q != HoldLast)) begin
          frame_cnt_d = frame_cnt_q + 10'd1;
        end
        // An accepted but out-of-range select still wins over next_req that clock.
        if (sel_accept) begin
          if (sel_id_ok) begin
            tgt_d   = sel_id_i;
            state_d = StPend;
          end else begin
            sel_err_d = 1'b1;
          end
        end else if (next_req_i) begin
          tgt_d   = next_src(cur_src_q, NumSrc);
          state_d = StPend;
        end else if (auto_en_i && fs && (frame_cnt_q == HoldLast)) begin
          tgt_d   = next_src(cur_src_q, NumSrc);
          state_d = StPend;
        end
        if (state_d != StShow) begin
          frame_cnt_d = '0;
        end
      end
      StPend: begin
        frame_cnt_d = '0;
        if (fs) begin
          state_d = StBlank;
        end
      end
      StBlank: begin
        frame_cnt_d = '0;
        if (fs) begin
          cur_src_d = tgt_q;
          state_d   = StShow;
        end
      end
      default: begin
        state_d = StShow;
      end
    endcase
  end

  always_comb begin
    src_pix = Rgb565Black;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (cur_src_q == 2'(i)) begin
        src_pix = src_data_i[16*i +: 16];
      end
    end
  end

  // vld is delayed one clock so it lines up with src_data, which trails pix_x/pix_y.
  assign vld_d      = (pix_x_i != InvCoord) && (pix_y_i != InvCoord);
  assign pix_data_d = !vld_q              ? Rgb565Black :
                      (state_q == StBlank) ? Rgb565Black : src_pix;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StShow;
      frame_cnt_q <= '0;
      tgt_q       <= '0;
      cur_src_q   <= '0;
      sel_err_q   <= 1'b0;
      vld_q       <= 1'b0;
      pix_data_q  <= Rgb565Black;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      tgt_q       <= tgt_d;
      cur_src_q   <= cur_src_d;
      sel_err_q   <= sel_err_d;
      vld_q       <= vld_d;
      pix_data_q  <= pix_data_d;
    end
  end

endmodule

// File: tb/tb_vga_src_sched.sv
// Directed bench for vga_src_sched on a tiny 6x4 raster (4x3 active) with constant-colour sources.
module tb_vga_src_sched;

  localparam logic [15:0] C0 = 16'hF800;
  localparam logic [15:0] C1 = 16'h07E0;
  localparam logic [15:0] C2 = 16'h001F;
  localparam logic [15:0] BK = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pix_x, pix_y;
  logic [47:0] src_data;
  logic        next_req, auto_en, sel_valid;
  logic [1:0]  sel_id;
  logic        sel_ready, sel_err, switching;
  logic [15:0] pix_data;
  logic [1:0]  cur_src;

  int n_pass  = 0;
  int n_total = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  vga_src_sched #(
    .NumSrc    (3),
    .FrameHold (10'd4),
    .InvCoord  (10'h3ff)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pix_x_i     (pix_x),
    .pix_y_i     (pix_y),
    .src_data_i  (src_data),
    .next_req_i  (next_req),
    .auto_en_i   (auto_en),
    .sel_valid_i (sel_valid),
    .sel_id_i    (sel_id),
    .sel_ready_o (sel_ready),
    .sel_err_o   (sel_err),
    .pix_data_o  (pix_data),
    .cur_src_o   (cur_src),
    .switching_o (switching)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One 24-clock frame. Pixel output after edge i reflects the pixel driven at i-1.
  task automatic run_frame(input logic [15:0] exp, input int ev_at, input logic ev_next,
                           input logic ev_sel, input logic [1:0] ev_id, input logic exp_err,
                           input int rst_at);
    logic prev_vld;
    logic cur_vld;
    int   row, col;
    prev_vld = 1'b0;
    for (int i = 0; i < 24; i++) begin
      row     = i / 6;
      col     = i % 6;
      cur_vld = (row < 3) && (col < 4);
      pix_x     = cur_vld ? 10'(col) : 10'h3ff;
      pix_y     = cur_vld ? 10'(row) : 10'h3ff;
      next_req  = (i == ev_at) ? ev_next : 1'b0;
      sel_valid = (i == ev_at) ? ev_sel : 1'b0;
      sel_id    = ev_id;
      rst       = (i == rst_at);
      @(posedge clk);
      #1;
      check($sformatf("pix f%0d i%0d", frame_no, i), pix_data, prev_vld ? exp : BK);
      if (i == ev_at) check($sformatf("sel_err f%0d", frame_no), 16'(sel_err), 16'(exp_err));
      if (i == ev_at + 1) check($sformatf("sel_err_end f%0d", frame_no), 16'(sel_err), 16'd0);
      if (i == rst_at) begin
        check("rst pix_data", pix_data, BK);
        check("rst cur_src", 16'(cur_src), 16'd0);
        check("rst switching", 16'(switching), 16'd0);
      end
      prev_vld = cur_vld;
    end
    next_req  = 1'b0;
    sel_valid = 1'b0;
    rst       = 1'b0;
    frame_no++;
  endtask

  task automatic plain_frame(input logic [15:0] exp);
    run_frame(exp, -10, 1'b0, 1'b0, 2'd0, 1'b0, -10);
  endtask

  task automatic check_status(input string tag, input logic [1:0] exp_cur, input logic exp_sw);
    check({tag, " cur_src"}, 16'(cur_src), 16'(exp_cur));
    check({tag, " switching"}, 16'(switching), 16'(exp_sw));
  endtask

  logic [15:0] auto_col [18] = '{C0, C0, C0, C0, BK, C1, C1, C1, C1, C1, BK,
                                 C2, C2, C2, C2, C2, BK, C0};
  logic [1:0]  auto_cur [18] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
  logic        auto_sw  [18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst       = 1'b1;
    pix_x     = 10'h3ff;
    pix_y     = 10'h3ff;
    src_data  = {C2, C1, C0};
    next_req  = 1'b0;
    auto_en   = 1'b0;
    sel_valid = 1'b0;
    sel_id    = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pix_data", pix_data, BK);
    check("reset sel_err", 16'(sel_err), 16'd0);
    check("reset sel_ready", 16'(sel_ready), 16'd1);
    check_status("reset", 2'd0, 1'b0);
    rst = 1'b0;

    // Two plain frames of source 0.
    plain_frame(C0);
    plain_frame(C0);
    check_status("src0", 2'd0, 1'b0);

    // next_req mid-frame: rest of frame src0, then one black frame, then src1.
    run_frame(C0, 10, 1'b1, 1'b0, 2'd0, 1'b0, -10);
    check_status("pend", 2'd0, 1'b1);
    check("pend sel_ready", 16'(sel_ready), 16'd0);
    plain_frame(BK);
    check_status("blank", 2'd0, 1'b1);
    plain_frame(C1);
    check_status("src1", 2'd1, 1'b0);

    // sel id 2 beats next_req in the same clock.
    run_frame(C1, 5, 1'b1, 1'b1, 2'd2, 1'b0, -10);
    check_status("sel2 pend", 2'd1, 1'b1);
    plain_frame(BK);
    plain_frame(C2);
    check_status("sel2", 2'd2, 1'b0);

    // Out-of-range sel: error pulse, no switch, concurrent next_req dropped.
    run_frame(C2, 7, 1'b1, 1'b1, 2'd3, 1'b1, -10);
    check_status("bad sel", 2'd2, 1'b0);
    plain_frame(C2);
    check_status("bad sel next", 2'd2, 1'b0);

    // Reset during BLANK abandons the pending switch to source 1.
    run_frame(C2, 3, 1'b0, 1'b1, 2'd1, 1'b0, -10);
    check_status("rst pend", 2'd2, 1'b1);
    run_frame(BK, -10, 1'b0, 1'b0, 2'd0, 1'b0, 20);
    plain_frame(C0);
    check_status("after rst", 2'd0, 1'b0);

    // Auto mode with FrameHold=4.
    auto_en = 1'b1;
    for (int f = 0; f < 18; f++) begin
      plain_frame(auto_col[f]);
      check_status($sformatf("auto %0d", f), auto_cur[f], auto_sw[f]);
    end
    auto_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
